rvb1_nibble_loader: RTL and testbench
=====================================

// Module: rvb1_nibble_loader
// PURPOSE
//  Upstream feeder for the rvb1 RISC-V core tile. Takes 4-bit nibbles strobed in on
//  the tile's io_in pins by an off-chip host, assembles them into 32-bit instruction
//  words and hands each word to the core over a valid/ready handshake. Includes
//  strobe synchronisation, edge detection, a one-word skid buffer and overflow
//  reporting.
// PARAMETERS
//  NIBBLES      8  nibbles per word; word width = 4*NIBBLES.
//  SYNC_STAGES  2  synchroniser flops on strobe_i and nib_i (>=2).
// PORTS
//  clk            in   1            tile clock (io_in[0]); the only clock.
//  rst_n          in   1            asynchronous, active-low reset.
//  strobe_i       in   1            host nibble strobe, asynchronous to clk.
//  nib_i          in   4            host nibble; stable while strobe_i is high.
//  instr_o        out  4*NIBBLES    assembled word to the core.
//  instr_valid_o  out  1            instr_o holds a word.
//  instr_ready_i  in   1            core accepts instr_o this cycle.
//  busy_o         out  1            assembly and output registers both full; host must pause.
//  nib_cnt_o      out  4            nibbles captured into the current word.
//  ovf_o          out  1            sticky: a strobe edge was dropped.
//  par_err_o      out  1            sticky parity error (0 unless RVB1_PARITY_EN).
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; sync chains, counter, and
//    assembly/output registers cleared; a word in flight is discarded.
//  - strobe_i and nib_i pass through SYNC_STAGES flops each; a nibble is captured on
//    the cycle the synced strobe is 1 and was 0 the previous cycle (one capture per
//    host pulse).
//  - Order is LSB first: the k-th captured nibble goes to bits [4k+3:4k];
//    nib_cnt_o increments per capture.
//  - When nib_cnt reaches NIBBLES, the word is complete:
//      * output reg empty, or draining this cycle (valid & ready): load it next cycle;
//        instr_valid_o high; nib_cnt_o returns to 0.
//      * otherwise: hold it in the assembly reg with nib_cnt_o = NIBBLES and busy_o = 1;
//        move it on the first cycle the output reg drains; busy_o drops the same cycle.
//  - Capture edge while busy_o = 1: nibble dropped, ovf_o set; only reset clears ovf_o.
//  - Handshake: instr_o/instr_valid_o stay stable until valid & ready.
//    Ready while not valid has no effect.
//  - Drain and load in the same cycle: the new word replaces the old one with no bubble.
//  - Latency: strobe_i rising edge to capture = SYNC_STAGES+1 clk.
//    Final capture to instr_valid_o = 1 clk.
// CONFIGURATION
//  RVB1_PARITY_EN defined: each word takes NIBBLES+1 captures. The extra nibble
//    carries even parity over the data word in bit 0; bits [3:1] are ignored.
//    - Match: deliver the word as above.
//    - Mismatch: discard the word and set sticky par_err_o.
//    - nib_cnt_o counts to NIBBLES+1 before clearing.
//  RVB1_PARITY_EN undefined: NIBBLES captures per word; par_err_o tied 0.
// TESTING
//  1. rst_n=0 mid-word after 3 nibbles, then release -> all outputs 0;
//     next 8 nibbles form a clean word.
//  2. Nibbles 3,9,0,0,0,5,0,0 with instr_ready_i=1 -> instr_o=32'h00500093,
//     instr_valid_o high 1 cycle, nib_cnt_o back to 0.
//  3. instr_ready_i=0; send words A=32'h00500093, then B=32'h00108113 ->
//     busy_o=1, A held stable.
//     Then 9th strobe -> ovf_o=1.
//     Then ready=1 -> A taken, B is presented the next cycle, busy_o=0.
//  4. strobe_i held high 20 clk -> exactly one capture.
//     strobe_i glitch shorter than 1 clk, clean pulses of >=2 clk -> one capture
//     per clean pulse.
//  5. Back-to-back words with ready=1 held: words arrive in order, no drops, ovf_o=0.
//  6. (RVB1_PARITY_EN) 32'h00500093 with parity nibble 1 -> dropped, par_err_o=1.
//     With parity nibble 0 -> delivered.

Source files
------------

// File: rtl/rvb1_nibble_loader.sv
// rvb1_nibble_loader: assembles host-strobed nibbles, LSB first, into instruction words for the rvb1 core.
// Build option RVB1_PARITY_EN: each word carries a trailing even-parity nibble, and a bad word raises sticky par_err_o.
module rvb1_nibble_loader #(
  parameter int NIBBLES     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 strobe_i,
  input  logic [3:0]           nib_i,
  output logic [4*NIBBLES-1:0] instr_o,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic                 busy_o,
  output logic [3:0]           nib_cnt_o,
  output logic                 ovf_o,
  output logic                 par_err_o
);
  localparam int W = 4 * NIBBLES;
`ifdef RVB1_PARITY_EN
  localparam int CAPS = NIBBLES + 1;
`else
  localparam int CAPS = NIBBLES;
`endif
  localparam logic [3:0] CAPS_CNT = 4'(CAPS);

  logic [SYNC_STAGES-1:0] strobe_sync;
  logic [3:0]             nib_sync [SYNC_STAGES];
  logic                   strobe_prev;
  logic                   capture;
  logic [3:0]             nib_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_sync <= '0;
      strobe_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) nib_sync[i] <= '0;
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], strobe_i};
      nib_sync[0] <= nib_i;
      for (int i = 1; i < SYNC_STAGES; i++) nib_sync[i] <= nib_sync[i-1];
      strobe_prev <= strobe_sync[SYNC_STAGES-1];
    end
  end

  assign capture = strobe_sync[SYNC_STAGES-1] & ~strobe_prev;
  assign nib_new = nib_sync[SYNC_STAGES-1];

  logic [W-1:0] asm_word;
  logic [3:0]   nib_cnt;
  logic [3:0]   base;
  logic         complete;
  logic         par_ok;
  logic         word_full;
  logic         can_load;
  logic         load;
  logic         discard;
  logic         accept;
  logic         drop;

`ifdef RVB1_PARITY_EN
  logic par_bit;
  logic par_err;
  assign par_ok = ((^asm_word) == par_bit);
`else
  assign par_ok = 1'b1;
`endif

  assign complete  = (nib_cnt == CAPS_CNT);
  assign word_full = complete & par_ok;
  assign discard   = complete & ~par_ok;
  assign can_load  = ~instr_valid_o | instr_ready_i;
  assign load      = word_full & can_load;
  assign busy_o    = word_full & ~can_load;
  assign accept    = capture & ~busy_o;
  assign drop      = capture & busy_o;
  // A word leaving (or being discarded) this cycle frees slot 0 for a new nibble.
  assign base      = (load | discard) ? 4'd0 : nib_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_word <= '0;
      nib_cnt  <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < NIBBLES; k++) begin
          if (base == 4'(k)) asm_word[4*k +: 4] <= nib_new;
        end
        nib_cnt <= base + 4'd1;
      end else if (load | discard) begin
        nib_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
    end else if (load) begin
      instr_o       <= asm_word;
      instr_valid_o <= 1'b1;
    end else if (instr_ready_i) begin
      instr_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_o <= 1'b0;
    else if (drop) ovf_o <= 1'b1;
  end

`ifdef RVB1_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (accept && base == 4'(NIBBLES)) par_bit <= nib_new[0];
      if (discard) par_err <= 1'b1;
    end
  end
  assign par_err_o = par_err;
`else
  assign par_err_o = 1'b0;
`endif

  assign nib_cnt_o = nib_cnt;

endmodule

// File: tb/tb_rvb1_nibble_loader.sv
// Bench for rvb1_nibble_loader: random words driven over the strobe protocol, checked against a word-level model.
// Honours RVB1_PARITY_EN the same way the design does.
module tb_rvb1_nibble_loader;
  localparam int NIBBLES = 8;
`ifdef RVB1_PARITY_EN
  localparam int NW = NIBBLES + 1;
`else
  localparam int NW = NIBBLES;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe_i = 1'b0;
  logic [3:0]  nib_i = 4'd0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        busy_o;
  logic [3:0]  nib_cnt_o;
  logic        ovf_o;
  logic        par_err_o;

  rvb1_nibble_loader #(.NIBBLES(NIBBLES), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .strobe_i(strobe_i), .nib_i(nib_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .busy_o(busy_o), .nib_cnt_o(nib_cnt_o), .ovf_o(ovf_o), .par_err_o(par_err_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  logic        rr_en = 1'b0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;

  // Nibble k of a word as the host sends it; the extra one is the even-parity bit.
  function automatic logic [3:0] nib_of(input logic [31:0] w, input int k);
    if (k < NIBBLES) return w[4*k +: 4];
    return {3'b000, ^w};
  endfunction

  // Observe handshakes 1ns before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (instr_valid_o !== 1'b1 || instr_o !== hold_d) begin
          errors++;
          $display("FAIL handshake_stable: valid=%b instr=%h, required valid=1 instr=%h",
                   instr_valid_o, instr_o, hold_d);
        end
      end
      if (instr_valid_o && instr_ready_i) rx_q.push_back(instr_o);
      hold_v = instr_valid_o && !instr_ready_i;
      hold_d = instr_o;
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (rr_en) instr_ready_i = 1'($urandom_range(0, 1));
  end

  task automatic do_reset();
    strobe_i = 1'b0;
    nib_i = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    rx_q.delete();
    @(negedge clk);
  endtask

  task automatic send_nibble(input logic [3:0] n);
    @(negedge clk);
    #1;
    nib_i = n;
    strobe_i = 1'b1;
    repeat (3) @(negedge clk);
    #1 strobe_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < NW; k++) send_nibble(nib_of(w, k));
    exp_q.push_back(w);
  endtask

  task automatic test_reset();
    logic [31:0] w;
    do_reset();
    checks++;
    if (instr_o !== 32'h0 || instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_out: instr=%h valid=%b, required 0/0", instr_o, instr_valid_o);
    end
    checks++;
    if (busy_o !== 1'b0 || nib_cnt_o !== 4'd0) begin
      errors++; $display("FAIL reset_cnt: busy=%b cnt=%0d, required 0/0", busy_o, nib_cnt_o);
    end
    checks++;
    if (ovf_o !== 1'b0 || par_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_sticky: ovf=%b par_err=%b, required 0/0", ovf_o, par_err_o);
    end
    instr_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) send_nibble(4'($urandom_range(0, 15)));
    checks++;
    if (nib_cnt_o !== 4'd3) begin
      errors++; $display("FAIL partial_cnt: cnt=%0d, required 3", nib_cnt_o);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (nib_cnt_o !== 4'd0 || instr_valid_o !== 1'b0 || busy_o !== 1'b0 || instr_o !== 32'h0) begin
      errors++;
      $display("FAIL midword_reset: cnt=%0d valid=%b busy=%b instr=%h, required all 0",
               nib_cnt_o, instr_valid_o, busy_o, instr_o);
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    w = $urandom;
    send_word(w);
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== w) begin
      errors++; $display("FAIL post_reset_word: got %0d words first=%h, required 1 word %h",
                         rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'h0, w);
    end
  endtask

  task automatic test_basic();
    logic [31:0] w;
    int lat;
    w = 32'h00500093;
    do_reset();
    instr_ready_i = 1'b1;
    @(negedge clk);
    #1;
    nib_i = nib_of(w, 0);
    strobe_i = 1'b1;
    lat = 0;
    while (nib_cnt_o == 4'd0 && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (lat != 3 || nib_cnt_o !== 4'd1) begin
      errors++; $display("FAIL capture_latency: %0d clk cnt=%0d, required 3 clk cnt=1", lat, nib_cnt_o);
    end
    repeat (2) @(negedge clk);
    #1 strobe_i = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 1; k < NW - 1; k++) send_nibble(nib_of(w, k));
    @(negedge clk);
    #1;
    nib_i = nib_of(w, NW - 1);
    strobe_i = 1'b1;
    lat = 0;
    while (nib_cnt_o != 4'(NW) && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (nib_cnt_o !== 4'(NW) || instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL final_capture: cnt=%0d valid=%b, required %0d/0", nib_cnt_o, instr_valid_o, NW);
    end
    @(posedge clk); #1;
    checks++;
    if (instr_valid_o !== 1'b1 || instr_o !== w || nib_cnt_o !== 4'd0) begin
      errors++; $display("FAIL word_out: valid=%b instr=%h cnt=%0d, required 1 %h 0",
                         instr_valid_o, instr_o, nib_cnt_o, w);
    end
    @(posedge clk); #1;
    checks++;
    if (instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL valid_pulse: valid=%b one cycle later, required 0", instr_valid_o);
    end
    @(negedge clk);
    #1 strobe_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== w) begin
      errors++; $display("FAIL basic_stream: %0d words received, required exactly %h once", rx_q.size(), w);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    a = 32'h00500093;
    b = 32'h00108113;
    do_reset();
    instr_ready_i = 1'b0;
    send_word(a);
    checks++;
    if (instr_valid_o !== 1'b1 || instr_o !== a || busy_o !== 1'b0) begin
      errors++; $display("FAIL bp_first: valid=%b instr=%h busy=%b, required 1 %h 0",
                         instr_valid_o, instr_o, busy_o, a);
    end
    send_word(b);
    checks++;
    if (busy_o !== 1'b1 || nib_cnt_o !== 4'(NW) || instr_o !== a) begin
      errors++; $display("FAIL bp_busy: busy=%b cnt=%0d instr=%h, required 1 %0d %h",
                         busy_o, nib_cnt_o, instr_o, NW, a);
    end
    send_nibble(4'($urandom_range(0, 15)));
    checks++;
    if (ovf_o !== 1'b1 || nib_cnt_o !== 4'(NW) || instr_o !== a) begin
      errors++; $display("FAIL bp_overflow: ovf=%b cnt=%0d instr=%h, required 1 %0d %h",
                         ovf_o, nib_cnt_o, instr_o, NW, a);
    end
    @(negedge clk);
    #1 instr_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (instr_o !== b || instr_valid_o !== 1'b1 || busy_o !== 1'b0 || nib_cnt_o !== 4'd0) begin
      errors++; $display("FAIL bp_release: instr=%h valid=%b busy=%b cnt=%0d, required %h 1 0 0",
                         instr_o, instr_valid_o, busy_o, nib_cnt_o, b);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== a || rx_q[1] !== b) begin
      errors++; $display("FAIL bp_order: %0d words received, required %h then %h", rx_q.size(), a, b);
    end
    checks++;
    if (ovf_o !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: ovf=%b, required 1", ovf_o);
    end
  endtask

  task automatic test_strobe_filter();
    logic [31:0] w;
    w = $urandom;
    do_reset();
    instr_ready_i = 1'b1;
    @(negedge clk);
    #1;
    nib_i = nib_of(w, 0);
    strobe_i = 1'b1;
    repeat (20) @(negedge clk);
    #1 strobe_i = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (nib_cnt_o !== 4'd1) begin
      errors++; $display("FAIL long_strobe: cnt=%0d, required 1", nib_cnt_o);
    end
    @(negedge clk);
    #1;
    nib_i = 4'($urandom_range(0, 15));
    strobe_i = 1'b1;
    #3 strobe_i = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (nib_cnt_o !== 4'd1) begin
      errors++; $display("FAIL glitch: cnt=%0d, required 1", nib_cnt_o);
    end
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      #1;
      nib_i = nib_of(w, k);
      strobe_i = 1'b1;
      repeat (2) @(negedge clk);
      #1 strobe_i = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (nib_cnt_o !== 4'd3) begin
      errors++; $display("FAIL short_pulses: cnt=%0d, required 3", nib_cnt_o);
    end
    for (int k = 3; k < NW; k++) send_nibble(nib_of(w, k));
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== w) begin
      errors++; $display("FAIL filter_word: %0d words first=%h, required 1 word %h",
                         rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'h0, w);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    instr_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) send_word($urandom);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ovf_o !== 1'b0 || par_err_o !== 1'b0) begin
      errors++; $display("FAIL b2b_sticky: ovf=%b par_err=%b, required 0/0", ovf_o, par_err_o);
    end
  endtask

  task automatic test_random_ready();
    logic [31:0] w;
    int t;
    do_reset();
    rr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      for (int k = 0; k < NW; k++) begin
        t = 0;
        while (nib_cnt_o == 4'(NW) && t < 200) begin
          @(negedge clk); t++;
        end
        if (t >= 200) begin
          checks++; errors++;
          $display("FAIL rr_stall: word still held after %0d clk, required release", t);
        end
        send_nibble(nib_of(w, k));
      end
      exp_q.push_back(w);
    end
    repeat (2) @(negedge clk);
    rr_en = 1'b0;
    #1 instr_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rr_count: %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rr_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ovf_o !== 1'b0) begin
      errors++; $display("FAIL rr_ovf: ovf=%b, required 0", ovf_o);
    end
  endtask

`ifdef RVB1_PARITY_EN
  task automatic test_parity();
    logic [31:0] w;
    w = 32'h00500093;
    do_reset();
    instr_ready_i = 1'b1;
    for (int k = 0; k < NIBBLES; k++) send_nibble(nib_of(w, k));
    send_nibble(4'd1);
    repeat (3) @(negedge clk);
    checks++;
    if (par_err_o !== 1'b1 || rx_q.size() != 0 || nib_cnt_o !== 4'd0) begin
      errors++; $display("FAIL parity_bad: par_err=%b words=%0d cnt=%0d, required 1 0 0",
                         par_err_o, rx_q.size(), nib_cnt_o);
    end
    send_word(w);
    repeat (3) @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== w || par_err_o !== 1'b1) begin
      errors++; $display("FAIL parity_good: words=%0d par_err=%b, required 1 word %h, par_err 1",
                         rx_q.size(), par_err_o, w);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_strobe_filter();
    test_back_to_back();
    test_random_ready();
`ifdef RVB1_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation still running at 2ms, required completion");
    $fatal(1, "timeout");
  end

endmodule
